// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command sequencer between an SPI slave and a single-port sync RAM.
// Each rx word is {cmd[1:0], payload[DATA_W-1:0]}:
//   00 set write address, 01 write data, 10 set read address, 11 read data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   rx_data, rx_valid     command word and its one-cycle strobe
//   mem_en, mem_we        RAM access / write enable
//   mem_addr, mem_wdata   RAM address / write data
//   mem_rdata             RAM read data, valid one cycle after a read access
//   tx_data, tx_valid     read data returned to the SPI slave, one-cycle strobe
//   busy                  FSM not idle
//   cmd_drop              one-cycle pulse: a command arrived while busy
// Build option: define SPI_RAM_CTRL_AUTOINC_EN to post-increment the write
// address after each write and the read address after each read.
module spi_ram_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] rx_data,
  input  logic              rx_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              busy,
  output logic              cmd_drop
);

  localparam logic [1:0] CMD_SET_WA = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RA = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [DATA_W-1:0] payload;
  } rx_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_REQ,
    S_RD_WAIT,
    S_RESP
  } state_e;

  rx_word_t          rx_w;
  logic [ADDR_W-1:0] pay_addr;

  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] tx_data_q,   tx_data_d;
  logic              tx_valid_q,  tx_valid_d;
  logic              busy_q,      busy_d;
  logic              cmd_drop_q,  cmd_drop_d;

  assign rx_w     = rx_data;
  assign pay_addr = rx_w.payload[ADDR_W-1:0];

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    cmd_drop_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_w.cmd)
            CMD_SET_WA: wr_addr_d = pay_addr;
            CMD_WRITE: begin
              state_d     = S_WRITE;
              mem_en_d    = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = wr_addr_q;
              mem_wdata_d = rx_w.payload;
            end
            CMD_SET_RA: rd_addr_d = pay_addr;
            CMD_READ: begin
              state_d    = S_RD_REQ;
              mem_en_d   = 1'b1;
              mem_addr_d = rd_addr_q;
            end
            default: ;
          endcase
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
        wr_addr_d = wr_addr_q + ADDR_W'(1);
`endif
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
        rd_addr_d = rd_addr_q + ADDR_W'(1);
`endif
      end
      // RAM data is valid now; register it straight into the response
      S_RD_WAIT: begin
        state_d    = S_RESP;
        tx_data_d  = mem_rdata;
        tx_valid_d = 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Commands are only sampled in IDLE; anything else is reported and lost
    if (rx_valid && (state_q != S_IDLE)) begin
      cmd_drop_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
      cmd_drop_q  <= cmd_drop_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign cmd_drop  = cmd_drop_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed bench for spi_ram_ctrl with a behavioural RAM,
// a transaction-level expectation model and a per-cycle output compare.
// Honours SPI_RAM_CTRL_AUTOINC_EN the same way the design does.
module tb_spi_ram_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int          DEPTH  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rx_data;
  logic        rx_valid;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        cmd_drop;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .cmd_drop  (cmd_drop)
  );

  // Single-port synchronous RAM, preloaded with addr ^ 0xA5
  logic [7:0] ram [256];
  bit         ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int a = 0; a < 256; a++) ram[a] = 8'(a) ^ 8'hA5;
      ram_loaded = 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
  end

  // Expected outputs per cycle, indexed by edge count modulo DEPTH
  bit         s_en   [DEPTH];
  bit         s_we   [DEPTH];
  bit         s_txv  [DEPTH];
  bit         s_busy [DEPTH];
  bit         s_drop [DEPTH];
  logic [7:0] s_addr [DEPTH];
  logic [7:0] s_wd   [DEPTH];
  logic [7:0] s_txd  [DEPTH];

  int         cyc = 0;
  int         busy_until = -10;
  logic [7:0] m_wa = 8'h00;
  logic [7:0] m_ra = 8'h00;
  logic [7:0] m_mem [256];
  bit         m_loaded = 1'b0;
  logic [7:0] cur_txd = 8'h00;

  function automatic int sl(input int c);
    return c % DEPTH;
  endfunction

  task automatic clr(input int j);
    s_en[j] = 1'b0; s_we[j] = 1'b0; s_txv[j] = 1'b0;
    s_busy[j] = 1'b0; s_drop[j] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [9:0] w);
    rx_data  = w;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;

    fork
      // Model: decide every accepted command's visible effects when it is sampled
      forever begin
        @(posedge clk);
        cyc++;
        if (!m_loaded) begin
          for (int a = 0; a < 256; a++) m_mem[a] = 8'(a) ^ 8'hA5;
          m_loaded = 1'b1;
        end
        if (!rst_n) begin
          for (int j = 0; j < DEPTH; j++) clr(j);
          m_wa = 8'h00;
          m_ra = 8'h00;
          busy_until = -10;
        end else begin
          clr(sl(cyc + 10));
          if (rx_valid) begin
            if (busy_until >= cyc - 1) begin
              s_drop[sl(cyc)] = 1'b1;
            end else begin
              case (rx_data[9:8])
                2'b00: m_wa = rx_data[7:0];
                2'b01: begin
                  s_en[sl(cyc)]   = 1'b1;
                  s_we[sl(cyc)]   = 1'b1;
                  s_addr[sl(cyc)] = m_wa;
                  s_wd[sl(cyc)]   = rx_data[7:0];
                  s_busy[sl(cyc)] = 1'b1;
                  m_mem[m_wa]     = rx_data[7:0];
                  busy_until      = cyc;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
                  m_wa = m_wa + 8'd1;
`endif
                end
                2'b10: m_ra = rx_data[7:0];
                default: begin
                  s_en[sl(cyc)]    = 1'b1;
                  s_we[sl(cyc)]    = 1'b0;
                  s_addr[sl(cyc)]  = m_ra;
                  for (int d = 0; d < 3; d++) s_busy[sl(cyc + d)] = 1'b1;
                  s_txv[sl(cyc + 2)] = 1'b1;
                  s_txd[sl(cyc + 2)] = m_mem[m_ra];
                  busy_until = cyc + 2;
`ifdef SPI_RAM_CTRL_AUTOINC_EN
                  m_ra = m_ra + 8'd1;
`endif
                end
              endcase
            end
          end
        end
      end
      // Compare: every cycle, shortly after the rising edge
      forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
          cur_txd = 8'h00;
          chk("rst mem_en",   32'(mem_en),    0);
          chk("rst mem_we",   32'(mem_we),    0);
          chk("rst mem_addr", 32'(mem_addr),  0);
          chk("rst wdata",    32'(mem_wdata), 0);
          chk("rst tx_data",  32'(tx_data),   0);
          chk("rst tx_valid", 32'(tx_valid),  0);
          chk("rst busy",     32'(busy),      0);
          chk("rst cmd_drop", 32'(cmd_drop),  0);
        end else begin
          chk("mem_en", 32'(mem_en), 32'(s_en[sl(cyc)]));
          chk("mem_we", 32'(mem_we), 32'(s_we[sl(cyc)]));
          if (s_en[sl(cyc)]) chk("mem_addr", 32'(mem_addr), 32'(s_addr[sl(cyc)]));
          if (s_en[sl(cyc)] && s_we[sl(cyc)])
            chk("mem_wdata", 32'(mem_wdata), 32'(s_wd[sl(cyc)]));
          chk("tx_valid", 32'(tx_valid), 32'(s_txv[sl(cyc)]));
          if (s_txv[sl(cyc)]) cur_txd = s_txd[sl(cyc)];
          chk("tx_data", 32'(tx_data), 32'(cur_txd));
          chk("busy", 32'(busy), 32'(s_busy[sl(cyc)]));
          chk("cmd_drop", 32'(cmd_drop), 32'(s_drop[sl(cyc)]));
        end
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("L rst mem_en",   32'(mem_en),    32'h0);
    chk("L rst mem_addr", 32'(mem_addr),  32'h0);
    chk("L rst wdata",    32'(mem_wdata), 32'h0);
    chk("L rst tx_data",  32'(tx_data),   32'h0);
    chk("L rst busy",     32'(busy),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0x55 to 0x0A
    send(10'h00A);
    send(10'h155);
    chk("L t1 mem_en",   32'(mem_en),    32'h1);
    chk("L t1 mem_we",   32'(mem_we),    32'h1);
    chk("L t1 mem_addr", 32'(mem_addr),  32'h0A);
    chk("L t1 wdata",    32'(mem_wdata), 32'h55);
    chk("L t1 busy",     32'(busy),      32'h1);
    @(negedge clk);
    chk("L t1 en off",   32'(mem_en),    32'h0);
    chk("L t1 idle",     32'(busy),      32'h0);

    // Read it back: response two cycles after the read strobe
    send(10'h20A);
    send(10'h300);
    chk("L t2 mem_en",   32'(mem_en),   32'h1);
    chk("L t2 mem_we",   32'(mem_we),   32'h0);
    chk("L t2 mem_addr", 32'(mem_addr), 32'h0A);
    @(negedge clk);
    chk("L t2 tx early", 32'(tx_valid), 32'h0);
    @(negedge clk);
    chk("L t2 tx_valid", 32'(tx_valid), 32'h1);
    chk("L t2 tx_data",  32'(tx_data),  32'h55);
    @(negedge clk);
    chk("L t2 tx off",   32'(tx_valid), 32'h0);
    chk("L t2 tx hold",  32'(tx_data),  32'h55);
    chk("L t2 idle",     32'(busy),     32'h0);

    // Command during a read is dropped
    send(10'h300);
    send(10'h155);
    chk("L t3 cmd_drop", 32'(cmd_drop), 32'h1);
    repeat (4) @(negedge clk);

    // Command right after WRITE is dropped, the one after that accepted
    send(10'h1AA);
    send(10'h133);
    chk("L t3 wr drop",  32'(cmd_drop), 32'h1);
    send(10'h144);
    chk("L t3 accept",   32'(mem_we),    32'h1);
    chk("L t3 wdata",    32'(mem_wdata), 32'h44);
    repeat (2) @(negedge clk);

    // Reset during RD_WAIT aborts the read and clears the address
    send(10'h20A);
    send(10'h300);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("L t4 tx_valid", 32'(tx_valid), 32'h0);
    chk("L t4 tx_data",  32'(tx_data),  32'h0);
    chk("L t4 busy",     32'(busy),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("L t4 no tx",    32'(tx_valid), 32'h0);
    send(10'h300);
    chk("L t4 addr0",    32'(mem_addr), 32'h00);
    repeat (2) @(negedge clk);
    chk("L t4 rd0 v",    32'(tx_valid), 32'h1);
    chk("L t4 rd0 d",    32'(tx_data),  32'hA5);
    @(negedge clk);

    // Address 0xFF followed by two writes: wrap with auto-increment
    send(10'h0FF);
    send(10'h111);
    chk("L t5 addr1", 32'(mem_addr), 32'hFF);
    @(negedge clk);
    send(10'h122);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
    chk("L t5 addr2", 32'(mem_addr), 32'h00);
`else
    chk("L t5 addr2", 32'(mem_addr), 32'hFF);
`endif
    chk("L t5 wdata2", 32'(mem_wdata), 32'h22);
    @(negedge clk);
    send(10'h2FF);
    send(10'h300);
    repeat (2) @(negedge clk);
`ifdef SPI_RAM_CTRL_AUTOINC_EN
    chk("L t5 rd FF", 32'(tx_data), 32'h11);
`else
    chk("L t5 rd FF", 32'(tx_data), 32'h22);
`endif
    @(negedge clk);
    send(10'h300);
    repeat (2) @(negedge clk);
    chk("L t5 rd next", 32'(tx_data), 32'h22);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
